ppu_sprite_pixel_fsm: RTL

Per-tile sprite pixel generator sitting directly downstream of the sprite-load stage in the PPU pipeline. For each 8-pixel tile it takes the two registered sprite descriptors (slot 0 / slot 1), fetches their pattern-plane bytes from CHR pattern memory, and applies flips, horizontal overlap and slot priority. It then publishes an 8-entry pixel buffer that the pixel mixer queries one column at a time.

---
 rtl/ppu_sprite_pixel_fsm_if.sv | 32 +++
 rtl/ppu_sprite_pixel_fsm.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ppu_sprite_pixel_fsm_if.sv
// ppu_sprite_pixel_fsm_if: tile request, sprite descriptors, CHR read port and pixel query bundle
interface ppu_sprite_pixel_fsm_if;
  logic        start;
  logic [8:0]  curr_row;
  logic [8:0]  curr_col;
  logic        sprite_table;
  logic        s0_on_tile, s1_on_tile;
  logic [7:0]  s0_tile_num, s1_tile_num;
  logic [7:0]  s0_row, s1_row;
  logic [7:0]  s0_col, s1_col;
  logic [7:0]  s0_attr, s1_attr;
  logic        s0_is_0, s1_is_0;
  logic [13:0] pat_addr;
  logic        pat_rd;
  logic [7:0]  pat_data_in;
  logic        busy;
  logic        done;
  logic [2:0]  pix_x;
  logic [3:0]  spr_color;
  logic        spr_behind_bg;
  logic        spr_s0_opaque;
  modport slave (
    input  start, curr_row, curr_col, sprite_table, s0_on_tile, s1_on_tile, s0_tile_num, s1_tile_num,
           s0_row, s1_row, s0_col, s1_col, s0_attr, s1_attr, s0_is_0, s1_is_0, pat_data_in, pix_x,
    output pat_addr, pat_rd, busy, done, spr_color, spr_behind_bg, spr_s0_opaque
  );
  modport master (
    output start, curr_row, curr_col, sprite_table, s0_on_tile, s1_on_tile, s0_tile_num, s1_tile_num,
           s0_row, s1_row, s0_col, s1_col, s0_attr, s1_attr, s0_is_0, s1_is_0, pat_data_in, pix_x,
    input  pat_addr, pat_rd, busy, done, spr_color, spr_behind_bg, spr_s0_opaque
  );
endinterface

// File: rtl/ppu_sprite_pixel_fsm.sv
// ppu_sprite_pixel_fsm: per-tile two-slot sprite fetch/compose into an 8-entry pixel buffer; ports clk, rst, bus (slave: tile request, CHR read, pixel query)
module ppu_sprite_pixel_fsm (
  input logic clk,
  input logic rst,
  ppu_sprite_pixel_fsm_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, COMPOSE} state_t;
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [8:0]  r_row;
  logic [8:0]  r_col;
  logic        r_table;
  logic [1:0]  r_on;
  logic [1:0]  r_is0;
  logic [7:0]  r_tile [2];
  logic [7:0]  r_srow [2];
  logic [7:0]  r_scol [2];
  logic [7:0]  r_attr [2];
  logic [7:0]  r_lo [2];
  logic [7:0]  r_hi [2];
  logic [5:0]  r_work [8];
  logic [5:0]  r_disp [8];
  logic [13:0] r_addr;
  logic        r_rd;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_color;
  logic        r_behind;
  logic        r_s0op;
  logic [9:0]  w_d [2];
  logic [2:0]  w_b [2];
  logic [1:0]  w_pat [2];
  logic [1:0]  w_op;
  logic        w_s0op;
  logic [5:0]  w_pix;
  logic [2:0]  w_nx;
  logic [2:0]  w_cap;
  logic [7:0]  w_data;
  logic        w_unused;
  function automatic logic [13:0] f_addr(input logic tbl, input logic [7:0] tile, input logic plane,
                                         input logic [2:0] crow, input logic [2:0] srow, input logic vf);
    logic [2:0] fy;
    fy = crow - srow;
    return {1'b0, tbl, tile, plane, vf ? ~fy : fy};
  endfunction
  assign w_nx   = r_cnt + 3'd1;
  assign w_cap  = r_cnt - 3'd1;
  assign w_data = r_on[w_cap[1]] ? bus.pat_data_in : 8'h00;
  assign w_unused = ^{r_attr[0][4:2], r_attr[1][4:2], r_row[8:3], r_srow[0][7:3], r_srow[1][7:3]};
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_d[s]   = {r_col[8], r_col} + {7'd0, r_cnt} - {2'd0, r_scol[s]};
      w_b[s]   = r_attr[s][6] ? w_d[s][2:0] : ~w_d[s][2:0];
      w_pat[s] = (w_d[s][9:3] == 7'd0) ? {r_hi[s][w_b[s]], r_lo[s][w_b[s]]} : 2'b00;
      w_op[s]  = |w_pat[s];
    end
    w_s0op = |(r_is0 & w_op);
    w_pix  = w_op[0] ? {r_attr[0][1:0], w_pat[0], r_attr[0][5], w_s0op} :
             w_op[1] ? {r_attr[1][1:0], w_pat[1], r_attr[1][5], w_s0op} : 6'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_color  <= '0;
      r_behind <= 1'b0;
      r_s0op   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_work[i] <= '0;
        r_disp[i] <= '0;
      end
    end else begin
      {r_color, r_behind, r_s0op} <= r_disp[bus.pix_x];
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state   <= FETCH;
          r_cnt     <= '0;
          r_busy    <= 1'b1;
          r_rd      <= 1'b1;
          r_addr    <= f_addr(bus.sprite_table, bus.s0_tile_num, 1'b0, bus.curr_row[2:0], bus.s0_row[2:0], bus.s0_attr[7]);
          r_row     <= bus.curr_row;
          r_col     <= bus.curr_col;
          r_table   <= bus.sprite_table;
          r_on      <= {bus.s1_on_tile, bus.s0_on_tile};
          r_is0     <= {bus.s1_is_0, bus.s0_is_0};
          r_tile[0] <= bus.s0_tile_num;
          r_tile[1] <= bus.s1_tile_num;
          r_srow[0] <= bus.s0_row;
          r_srow[1] <= bus.s1_row;
          r_scol[0] <= bus.s0_col;
          r_scol[1] <= bus.s1_col;
          r_attr[0] <= bus.s0_attr;
          r_attr[1] <= bus.s1_attr;
        end
        FETCH: begin
          r_cnt   <= (r_cnt == 3'd4) ? 3'd0 : w_nx;
          r_state <= (r_cnt == 3'd4) ? COMPOSE : FETCH;
          r_rd    <= r_cnt < 3'd3;
          if (r_cnt < 3'd3)
            r_addr <= f_addr(r_table, r_tile[w_nx[1]], w_nx[0], r_row[2:0], r_srow[w_nx[1]][2:0], r_attr[w_nx[1]][7]);
          if (r_cnt != 3'd0 && w_cap[0])
            r_hi[w_cap[1]] <= w_data;
          if (r_cnt != 3'd0 && !w_cap[0])
            r_lo[w_cap[1]] <= w_data;
        end
        COMPOSE: begin
          r_work[r_cnt] <= w_pix;
          r_cnt         <= w_nx;
          if (r_cnt == 3'd7) begin
            for (int i = 0; i < 7; i++) r_disp[i] <= r_work[i];
            r_disp[7] <= w_pix;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.pat_addr      = r_addr;
  assign bus.pat_rd        = r_rd;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.spr_color     = r_color;
  assign bus.spr_behind_bg = r_behind;
  assign bus.spr_s0_opaque = r_s0op;
endmodule
